// File: rtl/panel_input_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : panel_input_conditioner
//  Purpose  : Front end of the workout timer. Synchronises and debounces the
//             start/skip buttons into one-cycle pulses. Snapshots the profile
//             switches on every accepted start. Derives the 1 Hz FSM clock and
//             the ~2 kHz buzzer clock from the system clock.
//  Options  : SKIP_AUTOREPEAT_EN - when defined, a held skip button re-issues
//             skip_pulse every REP_CYCLES cycles after the previous pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module panel_input_conditioner #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int REP_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       skip_btn,
  input  logic [7:0] P_sw,
  output logic       start_pulse,
  output logic       skip_pulse,
  output logic [7:0] P_out,
  output logic       clk_1hz,
  output logic       clk_2khz
);

  // Half periods of the derived clocks (cycles between successive edges).
  localparam int HALF_1HZ  = CLK_HZ / 2;
  localparam int HALF_2KHZ = CLK_HZ / 4000;

  // Counter widths. The "+1" keeps the width non-zero when a half period is 1.
  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam int D1_W  = $clog2(HALF_1HZ + 1);
  localparam int D2_W  = $clog2(HALF_2KHZ + 1);

  localparam logic [DEB_W-1:0] C_DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [D1_W-1:0]  C_DIV1_LAST = D1_W'(HALF_1HZ - 1);
  localparam logic [D2_W-1:0]  C_DIV2_LAST = D2_W'(HALF_2KHZ - 1);

  // Reject configurations for which the derived clocks or the debouncer
  // would be meaningless.
  if ((CLK_HZ < 4000) || ((CLK_HZ % 4000) != 0)) begin : g_bad_clk_hz
    $error("panel_input_conditioner: CLK_HZ must be a multiple of 4000 and >= 4000");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb_cycles
    $error("panel_input_conditioner: DEB_CYCLES must be >= 2");
  end
  if (REP_CYCLES < 2) begin : g_bad_rep_cycles
    $error("panel_input_conditioner: REP_CYCLES must be >= 2");
  end

  // --------------------------------------------------------------------------
  // Synchronisers: bit 0 = start, bit 1 = skip. The profile bus is not
  // coherence-protected because the switches are static while in use.
  // --------------------------------------------------------------------------
  logic [1:0] btn_meta_q, btn_meta_d;
  logic [1:0] btn_sync_q, btn_sync_d;
  logic [7:0] p_meta_q,   p_meta_d;
  logic [7:0] p_sync_q,   p_sync_d;

  // Two-flop synchroniser next-state for buttons and profile switches.
  always_comb begin
    btn_meta_d = {skip_btn, start_btn};
    btn_sync_d = btn_meta_q;
    p_meta_d   = P_sw;
    p_sync_d   = p_meta_q;
  end

  // Synchroniser registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      p_meta_q   <= '0;
      p_sync_q   <= '0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      p_meta_q   <= p_meta_d;
      p_sync_q   <= p_sync_d;
    end
  end

  // --------------------------------------------------------------------------
  // Debouncers: a level change is accepted only after the synchronised input
  // has disagreed with the stable level for DEB_CYCLES consecutive cycles.
  // w_rise/w_fall are high on the edge at which the stable level changes.
  // --------------------------------------------------------------------------
  logic [1:0] w_level;
  logic [1:0] w_rise;
  logic [1:0] w_fall;

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             accept;

    // Count consecutive disagreeing cycles; accept the new level at the limit.
    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      accept  = 1'b0;
      if (btn_sync_q[gi] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == C_DEB_LAST) begin
        level_d = btn_sync_q[gi];
        cnt_d   = '0;
        accept  = 1'b1;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign w_level[gi] = level_q;
    assign w_rise[gi]  = accept &  btn_sync_q[gi];
    assign w_fall[gi]  = accept & ~btn_sync_q[gi];
  end

  // --------------------------------------------------------------------------
  // Skip auto-repeat. The counter restarts at every skip pulse and is held at
  // zero while the debounced skip is low. A repeat point that coincides with
  // the release edge is suppressed, so a release never yields a pulse.
  // --------------------------------------------------------------------------
  logic w_rep_fire;

`ifdef SKIP_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REP_CYCLES);
  localparam logic [REP_W-1:0] C_REP_LAST = REP_W'(REP_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  // Measure the interval since the previous skip pulse while skip is held.
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    w_rep_fire = 1'b0;
    if (!w_level[1] || w_fall[1]) begin
      rep_cnt_d = '0;
    end else if (rep_cnt_q == C_REP_LAST) begin
      rep_cnt_d  = '0;
      w_rep_fire = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + REP_W'(1);
    end
  end

  // Repeat interval register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output pulses and profile snapshot. The profile is captured on the same
  // edge that raises start_pulse, so P_out is valid while the pulse is high.
  // --------------------------------------------------------------------------
  logic       start_pulse_q, start_pulse_d;
  logic       skip_pulse_q,  skip_pulse_d;
  logic [7:0] p_out_q,       p_out_d;

  // Pulses only on 0->1 of the stable level (plus skip repeats).
  always_comb begin
    start_pulse_d = w_rise[0];
    skip_pulse_d  = w_rise[1] | w_rep_fire;
    p_out_d       = w_rise[0] ? p_sync_q : p_out_q;
  end

  // Pulse and profile registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_pulse_q <= 1'b0;
      skip_pulse_q  <= 1'b0;
      p_out_q       <= 8'h00;
    end else begin
      start_pulse_q <= start_pulse_d;
      skip_pulse_q  <= skip_pulse_d;
      p_out_q       <= p_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Clock dividers: each free-running counter wraps at HALF_x-1 and toggles
  // its output there, giving edges exactly HALF_x cycles apart.
  // --------------------------------------------------------------------------
  logic [D1_W-1:0] div1_cnt_q, div1_cnt_d;
  logic [D2_W-1:0] div2_cnt_q, div2_cnt_d;
  logic            clk_1hz_q,  clk_1hz_d;
  logic            clk_2khz_q, clk_2khz_d;

  // Divider next-state: count, wrap and toggle.
  always_comb begin
    div1_cnt_d = div1_cnt_q + D1_W'(1);
    clk_1hz_d  = clk_1hz_q;
    if (div1_cnt_q == C_DIV1_LAST) begin
      div1_cnt_d = '0;
      clk_1hz_d  = ~clk_1hz_q;
    end
    div2_cnt_d = div2_cnt_q + D2_W'(1);
    clk_2khz_d = clk_2khz_q;
    if (div2_cnt_q == C_DIV2_LAST) begin
      div2_cnt_d = '0;
      clk_2khz_d = ~clk_2khz_q;
    end
  end

  // Divider registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div1_cnt_q <= '0;
      div2_cnt_q <= '0;
      clk_1hz_q  <= 1'b0;
      clk_2khz_q <= 1'b0;
    end else begin
      div1_cnt_q <= div1_cnt_d;
      div2_cnt_q <= div2_cnt_d;
      clk_1hz_q  <= clk_1hz_d;
      clk_2khz_q <= clk_2khz_d;
    end
  end

  assign start_pulse = start_pulse_q;
  assign skip_pulse  = skip_pulse_q;
  assign P_out       = p_out_q;
  assign clk_1hz     = clk_1hz_q;
  assign clk_2khz    = clk_2khz_q;

endmodule
`default_nettype wire

// File: doc/panel_input_conditioner.md
# panel_input_conditioner

Front-end stage of the workout timer: takes raw board switches/buttons and the single board clock, and produces what the top level consumes. Synchronises and debounces `start`/`skip` into one-cycle pulses. Snapshots the packed profile word `P` on each accepted start. Derives the 1 Hz FSM clock and the ~2 kHz buzzer clock from the system clock. Sits directly upstream of the top-level workout datapath and drives its `start`, `skip`, `P`, `clk_1hz` and `clk_2khz` inputs.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; must be a multiple of 4000 and ≥ 4000.
- `DEB_CYCLES`, 1_000_000, consecutive stable cycles needed to accept a button level change (20 ms at 50 MHz); ≥ 2.
- `REP_CYCLES`, 25_000_000, skip auto-repeat interval in cycles; used only with the macro; ≥ 2.
- Derived, not overridable: `HALF_1HZ = CLK_HZ/2`, `HALF_2KHZ = CLK_HZ/4000`.
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start_btn`  in  1  raw start button, asynchronous, active-high.
- `skip_btn`  in  1  raw skip button, asynchronous, active-high.
- `P_sw`  in  8  raw profile switches `{G, MET[1:0], Cal[1:0], W[2:0]}`, asynchronous, quasi-static.
- `start_pulse`  out  1  one-cycle pulse per accepted start press.
- `skip_pulse`  out  1  one-cycle pulse per accepted skip press (plus repeats when enabled).
- `P_out`  out  8  profile captured at the last start pulse.
- `clk_1hz`  out  1  50 % square wave, period `CLK_HZ` cycles.
- `clk_2khz`  out  1  50 % square wave, period `CLK_HZ/2000` cycles.

## Operation
- Synchronisers: `start_btn`, `skip_btn` and each bit of `P_sw` pass through a 2-flop synchroniser. The `P_sw` bus is not coherence-protected; the switches are static during use.
- Debouncer, one per button:
  - State: stable level `d` (reset 0) and counter `cnt` (reset 0).
  - Synchronised level `s == d`: `cnt <= 0`.
  - `s != d` and `cnt < DEB_CYCLES-1`: `cnt++`.
  - `s != d` and `cnt == DEB_CYCLES-1`: `d <= s`, `cnt <= 0`.
  - A glitch shorter than `DEB_CYCLES` cycles changes nothing.
- Pulses:
  - `start_pulse` and `skip_pulse` are registered and high for exactly the one cycle following the edge at which `d` goes 0→1.
  - A 1→0 transition of `d` never produces a pulse.
- Profile capture: `P_out <= P_sync` on the same edge that raises `start_pulse`, so `P_out` is already valid while `start_pulse` is high. `P_out` holds its value otherwise.
- Dividers:
  - Two independent free-running counters.
  - `clk_1hz` toggles when its counter reaches `HALF_1HZ-1`; the counter then wraps to 0.
  - `clk_2khz` toggles the same way at `HALF_2KHZ-1`.
- Simultaneous presses: the two buttons are fully independent. Both pulses may assert in the same cycle; priority is resolved downstream.
- Reset mid-operation:
  - All counters, `d` levels, pulses, `P_out` and both clocks return to 0 immediately.
  - A button still held at reset release is seen as a new press and yields one pulse after the debounce time.

## Timing
- Reset values: `start_pulse=0`, `skip_pulse=0`, `P_out=8'h00`, `clk_1hz=0`, `clk_2khz=0`.
- Press latency: button first sampled high at edge k → pulse high during the cycle after edge k+1+`DEB_CYCLES` (synchroniser latency plus `DEB_CYCLES`).
- Release latency: same count, no output pulse.
- After reset release, first rising edge of `clk_1hz` occurs `HALF_1HZ` cycles in, and of `clk_2khz` `HALF_2KHZ` cycles in.
- Edges of each derived clock are exactly `HALF_x` cycles apart, with no drift.

## Configuration
- `SKIP_AUTOREPEAT_EN` defined:
  - While debounced skip stays 1, a repeat counter runs from the initial skip pulse.
  - Every `REP_CYCLES` cycles after the previous skip pulse, a further one-cycle `skip_pulse` is issued.
  - Release (`d`→0) or reset clears the counter.
- `SKIP_AUTOREPEAT_EN` undefined: exactly one `skip_pulse` per press; repeat logic absent.
- `start` never auto-repeats in either build.

## Test plan
All scenarios use `CLK_HZ=8000`, `DEB_CYCLES=4`, `REP_CYCLES=10`.
- Reset, then 8000 cycles idle → `clk_2khz` toggles every 2 cycles, `clk_1hz` rises at cycle 4000; both pulses stay 0 and `P_out=00`.
- `P_sw=8'hA5`, `start_btn` high at edge k and held → `start_pulse` high for exactly one cycle after edge k+5, with `P_out=A5` in that cycle; releasing the button gives no pulse.
- `skip_btn` glitches high for 3 cycles → no `skip_pulse`. A clean 4-cycle-stable press → one pulse.
- `start_btn` and `skip_btn` rise on the same edge → both pulses high in the same single cycle.
- `skip_btn` held 40 cycles with `SKIP_AUTOREPEAT_EN` → pulses at the debounce point, then every 10 cycles (4 total). Without the macro → 1 pulse.
- `reset` asserted mid-debounce while `start_btn` is held → outputs cleared at once; after release, one `start_pulse` 5 edges later.
